// File: rtl/axi4_pkg.sv
// Shared definitions for the AXI4 read responder: response codes, FSM encoding
// and a ceiling-log2 helper used to size address fields.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Number of bits needed to represent value (0 for value 0).
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/axi4_read_responder_if.sv
// AXI4 read address/data channel bundle between an initiator (master) and the
// read responder (slave).
interface axi4_read_responder_if #(
  parameter int C_DATA_WIDTH    = 32,
  parameter int C_ADDRESS_WIDTH = 32
);

  logic [C_ADDRESS_WIDTH-1:0] S_ARADDR;
  logic [7:0]                 S_ARLEN;
  logic                       S_ARVALID;
  logic                       S_ARREADY;
  logic [C_DATA_WIDTH-1:0]    S_RDATA;
  logic [1:0]                 S_RRESP;
  logic                       S_RVALID;
  logic                       S_RLAST;
  logic                       S_RREADY;

  modport master (
    output S_ARADDR, S_ARLEN, S_ARVALID, S_RREADY,
    input  S_ARREADY, S_RDATA, S_RRESP, S_RVALID, S_RLAST
  );

  modport slave (
    input  S_ARADDR, S_ARLEN, S_ARVALID, S_RREADY,
    output S_ARREADY, S_RDATA, S_RRESP, S_RVALID, S_RLAST
  );

endinterface

// File: rtl/sp_ram_rf.sv
// Read-first synchronous RAM: one write port, one registered read port whose
// output holds its last value while the read enable is low.
module sp_ram_rf #(
  parameter int C_WIDTH = 32,
  parameter int C_DEPTH = 1024,
  parameter int C_AW    = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [C_AW-1:0]    waddr_i,
  input  logic [C_WIDTH-1:0] wdata_i,
  input  logic               re_i,
  input  logic [C_AW-1:0]    raddr_i,
  output logic [C_WIDTH-1:0] rdata_o
);

  logic [C_WIDTH-1:0] mem_q [C_DEPTH];
  logic [C_WIDTH-1:0] rdata_q;

  // Storage is never reset; preload fills it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-edge write to the read address returns the pre-write word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_read_responder.sv
// AXI4 read responder serving INCR bursts from a local word memory, with a
// preload write port and a fixed wait-state delay before the first beat.
module axi4_read_responder
  import axi4_pkg::*;
#(
  parameter int C_DATA_WIDTH    = 32,
  parameter int C_ADDRESS_WIDTH = 32,
  parameter int C_MEM_DEPTH     = 1024,
  parameter int C_WAIT_CYCLES   = 2
) (
  input  logic                                CLK,
  input  logic                                RES_N,
  axi4_read_responder_if.slave                s_axi,
  input  logic                                W_EN,
  input  logic [clogb2(C_MEM_DEPTH-1)-1:0]    W_ADDR,
  input  logic [C_DATA_WIDTH-1:0]             W_DATA
);

  localparam int          OFF_BITS  = clogb2(C_DATA_WIDTH/8 - 1);
  localparam int          MEM_AW    = clogb2(C_MEM_DEPTH - 1);
  localparam logic [15:0] WAIT_LAST = 16'(C_WAIT_CYCLES - 1);

  state_t                     state_q;
  logic                       arready_q;
  logic                       rvalid_q;
  logic                       rlast_q;
  logic [1:0]                 rresp_q;
  logic [C_ADDRESS_WIDTH-1:0] ptr_q;
  logic [C_ADDRESS_WIDTH-1:0] ptr_d;
  logic [7:0]                 len_q;
  logic [7:0]                 beat_q;
  logic [15:0]                wait_q;

  logic                       in_range;
  logic                       load;
  logic                       last_hs;
  logic [C_DATA_WIDTH-1:0]    ram_rdata;

  // Full-width compare so addresses past the end never alias into the array.
  assign in_range = (ptr_q < C_ADDRESS_WIDTH'(C_MEM_DEPTH));
  assign ptr_d    = ptr_q + C_ADDRESS_WIDTH'(1);
  assign load     = (state_q == ST_BURST) && !rlast_q && (!rvalid_q || s_axi.S_RREADY);
  assign last_hs  = (state_q == ST_BURST) && rvalid_q && rlast_q && s_axi.S_RREADY;

  sp_ram_rf #(
    .C_WIDTH (C_DATA_WIDTH),
    .C_DEPTH (C_MEM_DEPTH),
    .C_AW    (MEM_AW)
  ) u_ram (
    .clk_i   (CLK),
    .rst_ni  (RES_N),
    .we_i    (W_EN),
    .waddr_i (W_ADDR),
    .wdata_i (W_DATA),
    .re_i    (load && in_range),
    .raddr_i (ptr_q[MEM_AW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      ptr_q     <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      wait_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          arready_q <= 1'b1;
          if (s_axi.S_ARVALID && arready_q) begin
            ptr_q     <= s_axi.S_ARADDR >> OFF_BITS;
            len_q     <= s_axi.S_ARLEN;
            beat_q    <= '0;
            wait_q    <= '0;
            arready_q <= 1'b0;
            state_q   <= (C_WAIT_CYCLES > 0) ? ST_WAIT : ST_BURST;
          end
        end

        ST_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            wait_q  <= '0;
            state_q <= ST_BURST;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end

        ST_BURST: begin
          if (last_hs) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (load) begin
            rvalid_q <= 1'b1;
            rlast_q  <= (beat_q == len_q);
            rresp_q  <= in_range ? RESP_OKAY : RESP_DECERR;
            ptr_q    <= ptr_d;
            beat_q   <= beat_q + 8'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Error beats carry zero data regardless of what the RAM register holds.
  assign s_axi.S_ARREADY = arready_q;
  assign s_axi.S_RVALID  = rvalid_q;
  assign s_axi.S_RLAST   = rlast_q;
  assign s_axi.S_RRESP   = rresp_q;
  assign s_axi.S_RDATA   = (rresp_q == RESP_DECERR) ? '0 : ram_rdata;

endmodule

// File: tb/tb_axi4_read_responder.sv
// Directed and randomized bursts checked against a word-array reference model
// of the responder's memory and AXI burst rules.
module tb_axi4_read_responder;

  localparam int W     = 2;
  localparam int DEPTH = 1024;

  logic        CLK;
  logic        RES_N;
  logic        W_EN;
  logic [9:0]  W_ADDR;
  logic [31:0] W_DATA;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [DEPTH];

  axi4_read_responder_if #(.C_DATA_WIDTH(32), .C_ADDRESS_WIDTH(32)) axi ();

  axi4_read_responder #(
    .C_DATA_WIDTH    (32),
    .C_ADDRESS_WIDTH (32),
    .C_MEM_DEPTH     (DEPTH),
    .C_WAIT_CYCLES   (W)
  ) dut (
    .CLK    (CLK),
    .RES_N  (RES_N),
    .s_axi  (axi),
    .W_EN   (W_EN),
    .W_ADDR (W_ADDR),
    .W_DATA (W_DATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    W_EN   = 1'b1;
    W_ADDR = a;
    W_DATA = d;
    @(posedge CLK);
    #1;
    W_EN = 1'b0;
    mem_m[a] = d;
  endtask

  function automatic bit pick_rready(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return (n % 4 == 0) || (n % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Presents AR and returns just after the handshake edge.
  task automatic ar_handshake(input logic [31:0] addr, input logic [7:0] len, output bit ok);
    int t;
    ok = 1'b0;
    axi.S_ARADDR  = addr;
    axi.S_ARLEN   = len;
    axi.S_ARVALID = 1'b1;
    t = 0;
    while (axi.S_ARREADY !== 1'b1 && t < 50) begin
      @(posedge CLK);
      #1;
      t++;
    end
    if (axi.S_ARREADY !== 1'b1) begin
      timeout_fail("arready_wait");
      axi.S_ARVALID = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    axi.S_ARVALID = 1'b0;
    ok = 1'b1;
  endtask

  task automatic run_burst(input string nm, input logic [31:0] addr, input logic [7:0] len,
                           input int mode, input int wr_edge,
                           input logic [9:0] wa, input logic [31:0] wd);
    logic [31:0] exp_d [$];
    logic [1:0]  exp_r [$];
    bit          exp_l [$];
    logic [31:0] wp;
    logic [31:0] snap_d;
    logic [1:0]  snap_r;
    logic        snap_l;
    bit          ok;
    bit          stalled;
    int          n;
    int          hs;
    int          first;

    for (int i = 0; i <= int'(len); i++) begin
      wp = (addr >> 2) + 32'(i);
      if (wp < DEPTH) begin
        exp_d.push_back(mem_m[wp[9:0]]);
        exp_r.push_back(2'b00);
      end else begin
        exp_d.push_back(32'h0);
        exp_r.push_back(2'b11);
      end
      exp_l.push_back(i == int'(len));
    end

    ar_handshake(addr, len, ok);
    if (!ok) return;
    check({nm, "_arready_drop"}, 64'(axi.S_ARREADY), 64'(0));

    n       = 0;
    hs      = 0;
    first   = -1;
    stalled = 1'b0;
    snap_d  = '0;
    snap_r  = '0;
    snap_l  = 1'b0;
    while (hs < int'(len) + 1 && n < 3000) begin
      axi.S_RREADY = pick_rready(mode, n);
      if (wr_edge >= 0 && n == wr_edge - 1) begin
        W_EN   = 1'b1;
        W_ADDR = wa;
        W_DATA = wd;
      end else begin
        W_EN = 1'b0;
      end
      if (axi.S_RVALID === 1'b1 && first < 0) begin
        first = n;
        if (mode == 0) check({nm, "_first_latency"}, 64'(n), 64'(W + 1));
      end
      if (stalled) begin
        check({nm, "_stall_vld"},  64'(axi.S_RVALID), 64'(1));
        check({nm, "_stall_data"}, 64'(axi.S_RDATA),  64'(snap_d));
        check({nm, "_stall_resp"}, 64'(axi.S_RRESP),  64'(snap_r));
        check({nm, "_stall_last"}, 64'(axi.S_RLAST),  64'(snap_l));
      end
      stalled = (axi.S_RVALID === 1'b1) && !axi.S_RREADY;
      snap_d  = axi.S_RDATA;
      snap_r  = axi.S_RRESP;
      snap_l  = axi.S_RLAST;
      if (axi.S_RVALID === 1'b1 && axi.S_RREADY) begin
        check($sformatf("%s_data%0d", nm, hs), 64'(axi.S_RDATA), 64'(exp_d[hs]));
        check($sformatf("%s_resp%0d", nm, hs), 64'(axi.S_RRESP), 64'(exp_r[hs]));
        check($sformatf("%s_last%0d", nm, hs), 64'(axi.S_RLAST), 64'(exp_l[hs]));
        hs++;
      end
      @(posedge CLK);
      #1;
      n++;
    end
    W_EN         = 1'b0;
    axi.S_RREADY = 1'b0;
    if (hs < int'(len) + 1) begin
      timeout_fail({nm, "_beats"});
      return;
    end
    if (mode == 0) check({nm, "_burst_cycles"}, 64'(n), 64'(W + 2 + int'(len)));
    check({nm, "_end_rvalid"},  64'(axi.S_RVALID),  64'(0));
    check({nm, "_end_rlast"},   64'(axi.S_RLAST),   64'(0));
    check({nm, "_end_arready"}, 64'(axi.S_ARREADY), 64'(1));
    if (wr_edge >= 0) mem_m[wa] = wd;
  endtask

  initial begin
    bit          ok;
    logic [31:0] ra;
    logic [7:0]  rl;

    RES_N         = 1'b0;
    W_EN          = 1'b0;
    W_ADDR        = '0;
    W_DATA        = '0;
    axi.S_ARADDR  = '0;
    axi.S_ARLEN   = '0;
    axi.S_ARVALID = 1'b0;
    axi.S_RREADY  = 1'b0;

    // Reset state, then ARREADY one edge after release.
    #12;
    check("rst_arready", 64'(axi.S_ARREADY), 64'(0));
    check("rst_rvalid",  64'(axi.S_RVALID),  64'(0));
    check("rst_rlast",   64'(axi.S_RLAST),   64'(0));
    check("rst_rresp",   64'(axi.S_RRESP),   64'(0));
    check("rst_rdata",   64'(axi.S_RDATA),   64'(0));
    #1 RES_N = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rst_arready", 64'(axi.S_ARREADY), 64'(1));

    for (int i = 0; i < DEPTH; i++) wr(10'(i), $urandom);
    for (int i = 0; i < 4; i++) wr(10'(32'h40 + i), 32'hA0A0_A000 + 32'(i));
    wr(10'h000, 32'hDEAD_BEEF);

    run_burst("basic", 32'h100, 8'd3, 0, -1, '0, '0);
    run_burst("bp_pattern", 32'h100, 8'd3, 1, -1, '0, '0);
    run_burst("single", 32'h000, 8'd0, 0, -1, '0, '0);
    run_burst("edge", 32'(1022 * 4), 8'd3, 0, -1, '0, '0);
    run_burst("far_oob", 32'h0010_0000, 8'd2, 2, -1, '0, '0);

    // Reset while beat 2 of 4 is presented.
    ar_handshake(32'h100, 8'd3, ok);
    if (ok) begin
      axi.S_RREADY = 1'b1;
      repeat (W + 3) @(posedge CLK);
      #1;
      check("mid_beat2_data", 64'(axi.S_RDATA), 64'(mem_m[10'h42]));
      #2 RES_N = 1'b0;
      #1;
      check("mid_rst_rvalid",  64'(axi.S_RVALID),  64'(0));
      check("mid_rst_rlast",   64'(axi.S_RLAST),   64'(0));
      check("mid_rst_rdata",   64'(axi.S_RDATA),   64'(0));
      check("mid_rst_arready", 64'(axi.S_ARREADY), 64'(0));
      axi.S_RREADY = 1'b0;
      @(posedge CLK);
      #3 RES_N = 1'b1;
      @(posedge CLK);
      #1;
      check("mid_rel_arready", 64'(axi.S_ARREADY), 64'(1));
      check("mid_rel_rvalid",  64'(axi.S_RVALID),  64'(0));
    end
    run_burst("after_rst", 32'h100, 8'd3, 0, -1, '0, '0);

    // Preload write on the edge that loads word 0x41: old data first, new data next time.
    run_burst("collide", 32'h100, 8'd3, 0, W + 2, 10'h041, 32'h0000_0055);
    run_burst("collide_new", 32'h100, 8'd3, 0, -1, '0, '0);

    for (int k = 0; k < 8; k++) begin
      ra = (32'($urandom_range(0, DEPTH + 20)) << 2) | 32'($urandom_range(0, 3));
      rl = 8'($urandom_range(0, 15));
      run_burst($sformatf("rnd%0d", k), ra, rl, 2, -1, '0, '0);
    end

    run_burst("len255", 32'($urandom_range(0, DEPTH - 256)) << 2, 8'd255, 0, -1, '0, '0);
    run_burst("len255_bp", 32'(DEPTH - 100) << 2, 8'd255, 2, -1, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
